// File: rtl/maxmin_pkg.sv
// maxmin_pkg: shared types and constants for the max/min burst stimulus source.
//   state_e       FSM states of the source (Idle, Send, Wait, Done)
//   LFSR_TAPS     Galois tap mask for the 16-bit right-shifting LFSR
//   LFSR_DEF_SEED value substituted when a zero seed is requested
//   DEF_BURST_LEN default samples per burst
//   lfsr_next()   one Galois step of the LFSR
package maxmin_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StWait,
        StDone
    } state_e;

    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] LFSR_DEF_SEED = 16'hACE1;
    localparam int unsigned DEF_BURST_LEN = 15;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/mm_lfsr16.sv
// mm_lfsr16: 16-bit Galois LFSR (right shift, taps LFSR_TAPS).
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset (state -> LFSR_DEF_SEED)
//   load    in   load seed this cycle (has priority over enable)
//   enable  in   advance one step this cycle
//   seed    in   16-bit seed; zero is replaced by LFSR_DEF_SEED (all-zero locks up)
//   state   out  current LFSR state
module mm_lfsr16
    import maxmin_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        enable,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LFSR_DEF_SEED;
        end else if (load) begin
            state <= (seed == 16'h0000) ? LFSR_DEF_SEED : seed;
        end else if (enable) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/maxmin_stim_src.sv
// maxmin_stim_src: self-checking traffic source for a max/min burst reducer.
// Sends one burst of BURST_LEN contiguous samples (LFSR or ramp), tracks the
// expected max/min, then compares the reducer's result and reports done/pass.
// Optional build macro: MAXMIN_SRC_TIMEOUT_EN enables a TMO_CYC response timeout
// in WAIT; without it WAIT holds until rsp_valid or rst.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   pulse: begin a burst (only honoured in IDLE)
//   mode       in   0 = LFSR samples, 1 = ramp samples (captured at start)
//   seed       in   LFSR seed / ramp base in seed[7:0] (captured at start)
//   num_valid  out  high for BURST_LEN consecutive cycles per burst
//   num        out  sample, 0 while num_valid is low
//   rsp_valid  in   reducer result strobe
//   rsp_max    in   reducer max
//   rsp_min    in   reducer min
//   busy       out  state != IDLE
//   done       out  one-cycle pulse when a burst completes
//   pass       out  result of the last burst, held until next start
//   proto_err  out  sticky: unexpected rsp_valid or timeout; cleared only by rst
module maxmin_stim_src
    import maxmin_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BURST_LEN = DEF_BURST_LEN,
    parameter int unsigned TMO_CYC   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [15:0]       seed,
    output logic              num_valid,
    output logic [DATA_W-1:0] num,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_max,
    input  logic [DATA_W-1:0] rsp_min,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              proto_err
);

    localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    if (BURST_LEN < 2 || DATA_W < 1 || DATA_W > 16 || TMO_CYC < 1) begin : g_param_chk
        $error("maxmin_stim_src: unsupported parameter combination");
    end

    state_e            state;
    logic [CNT_W-1:0]  cnt;
    logic              mode_q;
    logic [DATA_W-1:0] ramp;
    logic [DATA_W-1:0] exp_max;
    logic [DATA_W-1:0] exp_min;
    logic [DATA_W-1:0] sample;
    logic [15:0]       lfsr_state;
    logic              lfsr_load;
    logic              lfsr_en;
    logic              last_sample;
    logic              match;
    logic              unused_lfsr;

`ifdef MAXMIN_SRC_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;
`endif

    // LFSR is loaded on the accepted start so its state is the first sample.
    assign lfsr_load = (state == StIdle) && start;
    assign lfsr_en   = (state == StSend);

    mm_lfsr16 u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load   (lfsr_load),
        .enable (lfsr_en),
        .seed   (seed),
        .state  (lfsr_state)
    );

    // Only the low DATA_W bits form the sample; the rest only feed the recurrence.
    assign unused_lfsr = ^lfsr_state;

    always_comb begin
        sample = mode_q ? ramp : lfsr_state[DATA_W-1:0];
    end

    assign num_valid   = (state == StSend);
    assign num         = num_valid ? sample : '0;
    assign busy        = (state != StIdle);
    assign last_sample = (cnt == CNT_W'(BURST_LEN - 1));
    assign match       = (rsp_max == exp_max) && (rsp_min == exp_min);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            cnt       <= '0;
            mode_q    <= 1'b0;
            ramp      <= '0;
            exp_max   <= '0;
            exp_min   <= '1;
            done      <= 1'b0;
            pass      <= 1'b0;
            proto_err <= 1'b0;
`ifdef MAXMIN_SRC_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            done <= 1'b0;
            // Any response outside WAIT is a protocol error, including one that
            // coincides with the last sample.
            if (rsp_valid && (state != StWait)) begin
                proto_err <= 1'b1;
            end
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state   <= StSend;
                        cnt     <= '0;
                        mode_q  <= mode;
                        ramp    <= DATA_W'(seed[7:0]);
                        exp_max <= '0;
                        exp_min <= '1;
                        pass    <= 1'b0;
                    end
                end
                StSend: begin
                    exp_max <= (sample > exp_max) ? sample : exp_max;
                    exp_min <= (sample < exp_min) ? sample : exp_min;
                    ramp    <= ramp + 1'b1;
                    cnt     <= cnt + 1'b1;
                    if (last_sample) begin
                        state <= StWait;
`ifdef MAXMIN_SRC_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                end
                StWait: begin
                    if (rsp_valid) begin
                        pass  <= match;
                        state <= StDone;
                    end
`ifdef MAXMIN_SRC_TIMEOUT_EN
                    else if (tmo_cnt == TMO_W'(TMO_CYC - 1)) begin
                        pass      <= 1'b0;
                        proto_err <= 1'b1;
                        state     <= StDone;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                StDone: begin
                    done  <= 1'b1;
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maxmin_stim_src.sv
// Bench for maxmin_stim_src: pairs the source with a behavioural max/min reducer
// that can be biased, silenced or forced, and checks directed scenarios.
module tb_maxmin_stim_src;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [15:0] seed;
    logic        num_valid;
    logic [7:0]  num;
    logic        rsp_valid;
    logic [7:0]  rsp_max;
    logic [7:0]  rsp_min;
    logic        busy;
    logic        done;
    logic        pass;
    logic        proto_err;

    int checks = 0;
    int errors = 0;

    // Reducer model controls.
    logic        force_rsp   = 1'b0;
    logic        suppress    = 1'b0;
    logic [7:0]  max_bias    = 8'h00;

    logic [3:0]  r_cnt;
    logic [7:0]  r_max;
    logic [7:0]  r_min;
    logic [7:0]  nmax;
    logic [7:0]  nmin;
    logic        red_valid;
    logic [7:0]  red_max;
    logic [7:0]  red_min;

    // Burst capture results.
    logic [7:0]  samp [0:31];
    int          n_samp;
    int          first_valid;
    int          done_at;
    int          done_cnt;

    logic [7:0]  lfsr_exp [0:14];

    always #5 clk = ~clk;

    maxmin_stim_src #(
        .DATA_W    (8),
        .BURST_LEN (15),
        .TMO_CYC   (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .seed      (seed),
        .num_valid (num_valid),
        .num       (num),
        .rsp_valid (rsp_valid),
        .rsp_max   (rsp_max),
        .rsp_min   (rsp_min),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .proto_err (proto_err)
    );

    // Reducer: accumulates while num_valid is high, clears on any low cycle,
    // returns a registered result the cycle after the 15th sample.
    always @(posedge clk) begin
        red_valid <= 1'b0;
        if (rst || !num_valid) begin
            r_cnt <= 4'd0;
            r_max <= 8'h00;
            r_min <= 8'hFF;
        end else begin
            nmax = (num > r_max) ? num : r_max;
            nmin = (num < r_min) ? num : r_min;
            r_cnt <= r_cnt + 4'd1;
            r_max <= nmax;
            r_min <= nmin;
            if (r_cnt == 4'd14) begin
                red_valid <= !suppress;
                red_max   <= nmax + max_bias;
                red_min   <= nmin;
            end
        end
    end

    assign rsp_valid = red_valid | force_rsp;
    assign rsp_max   = red_max;
    assign rsp_min   = red_min;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pulse start, then observe up to `limit` cycles (cycle k = k cycles after the
    // start cycle). force_at/restart_at pulse rsp_valid/start in that cycle.
    task automatic run_burst(input logic m, input logic [15:0] s, input int force_at,
                             input int restart_at, input int limit);
        @(negedge clk);
        mode  = m;
        seed  = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Inputs change after start to show they were captured.
        mode  = ~m;
        seed  = 16'h5A5A;
        n_samp = 0;
        first_valid = -1;
        done_at = -1;
        done_cnt = 0;
        for (int k = 1; k <= limit; k++) begin
            force_rsp = (k == force_at);
            start     = (k == restart_at);
            if (num_valid) begin
                if (n_samp < 32) samp[n_samp] = num;
                n_samp++;
                if (first_valid < 0) first_valid = k;
            end
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (done_at >= 0 && k >= done_at + 2) break;
            @(negedge clk);
        end
        force_rsp = 1'b0;
        start     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        mode = 1'b0;
        seed = 16'h0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({num_valid, num, busy, done, pass, proto_err} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got nv=%b num=%h busy=%b done=%b pass=%b perr=%b required all 0",
                     num_valid, num, busy, done, pass, proto_err);
        end
    endtask

    task automatic test_ramp_basic();
        logic [7:0] e;
        run_burst(1'b1, 16'h0010, 0, 0, 40);
        checks++;
        if (first_valid !== 1) begin
            errors++;
            $display("FAIL ramp_first_valid: got cycle %0d required 1", first_valid);
        end
        checks++;
        if (n_samp !== 15) begin
            errors++;
            $display("FAIL ramp_count: got %0d samples required 15", n_samp);
        end
        for (int i = 0; i < 15; i++) begin
            e = 8'h10 + 8'(i);
            checks++;
            if (samp[i] !== e) begin
                errors++;
                $display("FAIL ramp_sample[%0d]: got %h required %h", i, samp[i], e);
            end
        end
        checks++;
        if (done_at !== 18 || done_cnt !== 1) begin
            errors++;
            $display("FAIL ramp_done: got at %0d count %0d required at 18 count 1", done_at, done_cnt);
        end
        checks++;
        if (pass !== 1'b1 || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL ramp_pass: got pass=%b perr=%b required 1/0", pass, proto_err);
        end
    endtask

    task automatic test_ramp_wrap();
        logic [7:0] e;
        run_burst(1'b1, 16'h00F8, 0, 0, 40);
        for (int i = 0; i < 15; i++) begin
            e = 8'hF8 + 8'(i);
            checks++;
            if (samp[i] !== e) begin
                errors++;
                $display("FAIL wrap_sample[%0d]: got %h required %h", i, samp[i], e);
            end
        end
        checks++;
        if (red_max !== 8'hFF || red_min !== 8'h00) begin
            errors++;
            $display("FAIL wrap_minmax: got %h/%h required ff/00", red_max, red_min);
        end
        checks++;
        if (pass !== 1'b1 || done_cnt !== 1) begin
            errors++;
            $display("FAIL wrap_pass: got pass=%b done_cnt=%0d required 1/1", pass, done_cnt);
        end
    endtask

    task automatic test_lfsr();
        lfsr_exp = '{8'hE1, 8'h70, 8'h38, 8'h9C, 8'h4E, 8'h27, 8'h13, 8'h89,
                     8'hC4, 8'h62, 8'hB1, 8'h58, 8'h2C, 8'h16, 8'h8B};
        for (int b = 0; b < 2; b++) begin
            run_burst(1'b0, 16'h0000, 0, 0, 40);
            checks++;
            if (n_samp !== 15) begin
                errors++;
                $display("FAIL lfsr_count[b%0d]: got %0d required 15", b, n_samp);
            end
            for (int i = 0; i < 15; i++) begin
                checks++;
                if (samp[i] !== lfsr_exp[i]) begin
                    errors++;
                    $display("FAIL lfsr_sample[b%0d][%0d]: got %h required %h",
                             b, i, samp[i], lfsr_exp[i]);
                end
            end
            checks++;
            if (pass !== 1'b1 || done_at !== 18) begin
                errors++;
                $display("FAIL lfsr_pass[b%0d]: got pass=%b done_at=%0d required 1/18",
                         b, pass, done_at);
            end
        end
    endtask

    task automatic test_bad_rsp();
        max_bias = 8'h01;
        run_burst(1'b1, 16'h0030, 0, 0, 40);
        max_bias = 8'h00;
        checks++;
        if (pass !== 1'b0 || done_cnt !== 1) begin
            errors++;
            $display("FAIL bad_rsp: got pass=%b done_cnt=%0d required 0/1", pass, done_cnt);
        end
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL bad_rsp_perr: got %b required 0", proto_err);
        end
        run_burst(1'b1, 16'h0031, 0, 0, 40);
        checks++;
        if (pass !== 1'b1) begin
            errors++;
            $display("FAIL good_after_bad: got pass=%b required 1", pass);
        end
    endtask

    task automatic test_proto_err();
        run_burst(1'b1, 16'h0040, 5, 8, 40);
        checks++;
        if (proto_err !== 1'b1) begin
            errors++;
            $display("FAIL perr_send: got %b required 1", proto_err);
        end
        checks++;
        if (n_samp !== 15 || done_cnt !== 1) begin
            errors++;
            $display("FAIL start_while_busy: got %0d samples %0d done required 15/1",
                     n_samp, done_cnt);
        end
        run_burst(1'b1, 16'h0050, 0, 0, 40);
        checks++;
        if (proto_err !== 1'b1 || pass !== 1'b1) begin
            errors++;
            $display("FAIL perr_sticky: got perr=%b pass=%b required 1/1", proto_err, pass);
        end
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        mode  = 1'b1;
        seed  = 16'h0060;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        // Now in the 7th SEND cycle.
        checks++;
        if (num_valid !== 1'b1 || num !== 8'h66) begin
            errors++;
            $display("FAIL mid_burst_pre: got nv=%b num=%h required 1/66", num_valid, num);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (num_valid !== 1'b0 || busy !== 1'b0 || num !== 8'h00 || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_burst_rst: got nv=%b busy=%b num=%h perr=%b required 0/0/00/0",
                     num_valid, busy, num, proto_err);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_early_rsp();
        run_burst(1'b1, 16'h0070, 15, 0, 40);
        checks++;
        if (proto_err !== 1'b1) begin
            errors++;
            $display("FAIL early_rsp_last: got perr=%b required 1", proto_err);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        suppress = 1'b1;
        run_burst(1'b1, 16'h0020, 0, 0, 120);
        suppress = 1'b0;
`ifdef MAXMIN_SRC_TIMEOUT_EN
        checks++;
        if (done_at !== 81 || done_cnt !== 1) begin
            errors++;
            $display("FAIL timeout_done: got at %0d count %0d required at 81 count 1",
                     done_at, done_cnt);
        end
        checks++;
        if (pass !== 1'b0 || proto_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flags: got pass=%b perr=%b required 0/1", pass, proto_err);
        end
`else
        checks++;
        if (done_cnt !== 0 || busy !== 1'b1 || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL wait_hold: got done_cnt=%0d busy=%b perr=%b required 0/1/0",
                     done_cnt, busy, proto_err);
        end
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_ramp_basic();
        test_ramp_wrap();
        test_lfsr();
        test_bad_rsp();
        test_proto_err();
        test_reset_mid_burst();
        test_early_rsp();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
